// File: rtl/dmi_reg_slave.sv
// dmi_reg_slave: DMI target implementing a reduced debug-module register map with a fixed-latency abstract command window.
// Optional build macro DMI_REG_SLAVE_PERF_EN adds a read-only accepted-request counter at address 0x7F.
module dmi_reg_slave #(
   parameter int unsigned NrDataRegs = 2,
   parameter int unsigned CmdLatency = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [40:0] dmi_req_i,
   input  logic        dmi_req_valid_i,
   output logic        dmi_req_ready_o,
   output logic [33:0] dmi_resp_o,
   output logic        dmi_resp_valid_o,
   input  logic        dmi_resp_ready_i,
   output logic        dmactive_o,
   output logic        haltreq_o,
   output logic        cmd_busy_o
);
   typedef enum logic {S_IDLE, S_RESP} state_t;
   state_t      r_state, w_state_nx;
   logic [6:0]  w_addr, w_idx;
   logic [1:0]  w_op;
   logic [31:0] w_wdata, w_rdata, w_abscs;
   logic        w_acc, w_rd, w_wr, w_is_data, w_ctl_wr, w_cs_wr, w_cmd_wr, w_data_wr;
   logic        w_clr, w_start, w_done;
   logic [2:0]  w_cmderr_nx;
   logic        r_dmactive, r_haltreq, r_busy;
   logic [2:0]  r_cmderr;
   logic [7:0]  r_cnt, r_cmdtype;
   logic [31:0] r_data [NrDataRegs];
   logic [31:0] r_resp_data;
`ifdef DMI_REG_SLAVE_PERF_EN
   logic [31:0] r_perf;
`endif

   assign {w_addr, w_op, w_wdata} = dmi_req_i;
   assign w_acc     = dmi_req_valid_i & dmi_req_ready_o;
   assign w_rd      = w_acc && (w_op == 2'd1);
   assign w_wr      = w_acc && (w_op == 2'd2);
   assign w_is_data = (w_addr >= 7'h04) && (w_addr < 7'(4 + NrDataRegs));
   assign w_idx     = w_addr - 7'h04;
   assign w_ctl_wr  = w_wr && (w_addr == 7'h10);
   assign w_cs_wr   = w_wr && (w_addr == 7'h16);
   assign w_cmd_wr  = w_wr && (w_addr == 7'h17);
   assign w_data_wr = w_wr && w_is_data;
   assign w_done    = r_busy && (r_cnt == 8'd1);
   // an inactive DM, or a write dropping dmactive, forces all debug state back to zero
   assign w_clr     = !r_dmactive || (w_ctl_wr && !w_wdata[0]);
   assign w_start   = w_cmd_wr && (r_cmderr == 3'd0) && !r_busy;
   assign w_abscs   = {19'd0, r_busy, 1'b0, r_cmderr, 4'd0, 4'(NrDataRegs)};

   assign dmi_resp_o = {r_resp_data, 2'b00};
   assign dmactive_o = r_dmactive;
   assign haltreq_o  = r_haltreq;
   assign cmd_busy_o = r_busy;

   // handshake state register: one outstanding request at a time
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nx;
   end

   // next state and handshake outputs
   always_comb begin
      w_state_nx       = r_state;
      dmi_req_ready_o  = 1'b0;
      dmi_resp_valid_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            dmi_req_ready_o = 1'b1;
            if (dmi_req_valid_i) w_state_nx = S_RESP;
         end
         S_RESP: begin
            dmi_resp_valid_o = 1'b1;
            if (dmi_resp_ready_i) w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // read mux over the pre-write register state
   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < int'(NrDataRegs); i++) w_rdata = (w_is_data && w_idx == 7'(i)) ? r_data[i] : w_rdata;
      case (w_addr)
         7'h10:   w_rdata = {r_haltreq, 30'd0, r_dmactive};
         7'h11:   w_rdata = 32'h0000_0082;
         7'h16:   w_rdata = w_abscs;
`ifdef DMI_REG_SLAVE_PERF_EN
         7'h7F:   w_rdata = r_perf;
`endif
         default: ;
      endcase
   end

   // cmderr update: W1C first, then busy collisions, and a failing completion overrides both
   always_comb begin
      w_cmderr_nx = w_cs_wr ? (r_cmderr & ~w_wdata[10:8]) : r_cmderr;
      w_cmderr_nx = ((w_cmd_wr || w_data_wr) && r_busy && r_cmderr == 3'd0) ? 3'd1 : w_cmderr_nx;
      w_cmderr_nx = (w_done && r_cmdtype != 8'd0) ? 3'd2 : w_cmderr_nx;
   end

   // response data captured at acceptance and held until the response handshake
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    r_resp_data <= '0;
      else if (w_acc) r_resp_data <= w_rd ? w_rdata : '0;
   end

   // dmactive is always writable and survives its own clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       r_dmactive <= 1'b0;
      else if (w_ctl_wr) r_dmactive <= w_wdata[0];
   end

   // debug register state, command window and data registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni || w_clr) begin
         r_haltreq <= 1'b0;
         r_busy    <= 1'b0;
         r_cmderr  <= 3'd0;
         r_cnt     <= 8'd0;
         r_cmdtype <= 8'd0;
         for (int i = 0; i < int'(NrDataRegs); i++) r_data[i] <= '0;
      end else begin
         r_cmderr <= w_cmderr_nx;
         if (w_ctl_wr) r_haltreq <= w_wdata[31];
         if (w_start) begin
            r_busy    <= 1'b1;
            r_cnt     <= 8'(CmdLatency);
            r_cmdtype <= w_wdata[31:24];
         end else if (r_busy) begin
            r_cnt <= r_cnt - 8'd1;
            if (w_done) r_busy <= 1'b0;
         end
         for (int i = 0; i < int'(NrDataRegs); i++)
            if (w_data_wr && !r_busy && w_idx == 7'(i)) r_data[i] <= w_wdata;
      end
   end

`ifdef DMI_REG_SLAVE_PERF_EN
   // accepted-request counter, cleared only by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    r_perf <= '0;
      else if (w_acc) r_perf <= r_perf + 32'd1;
   end
`endif
endmodule

// File: tb/tb_dmi_reg_slave.sv
// tb_dmi_reg_slave: directed vector table, hand sequences and randomized traffic against a timestamp-based model.
module tb_dmi_reg_slave;
   localparam int CMD_LAT = 4;
   localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;

   logic        clk, rst_ni;
   logic [40:0] dmi_req_i;
   logic        dmi_req_valid_i, dmi_req_ready_o;
   logic [33:0] dmi_resp_o;
   logic        dmi_resp_valid_o, dmi_resp_ready_i;
   logic        dmactive_o, haltreq_o, cmd_busy_o;

   dmi_reg_slave #(.NrDataRegs(2), .CmdLatency(CMD_LAT)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .dmi_req_i(dmi_req_i), .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
      .dmi_resp_o(dmi_resp_o), .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i),
      .dmactive_o(dmactive_o), .haltreq_o(haltreq_o), .cmd_busy_o(cmd_busy_o)
   );

   int checks = 0, failures = 0;
   int cyc = 0, busy_tot = 0, e_acc = 0;
   logic s_busy, s_halt, s_act;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) busy_tot <= busy_tot + (cmd_busy_o ? 1 : 0);

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // one full DMI transaction; resp_ready is withheld for 'hold' cycles
   task automatic xact(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d, input int hold, output logic [31:0] rd);
      int n;
      logic [33:0] r0;
      @(negedge clk);
      n = 0;
      while (!dmi_req_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("req_ready_wait", {63'd0, dmi_req_ready_o}, 64'd1);
      dmi_req_i = {a, op, d};
      dmi_req_valid_i = 1'b1;
      dmi_resp_ready_i = 1'b0;
      @(posedge clk);
      e_acc = cyc;
      #1 dmi_req_valid_i = 1'b0;
      dmi_req_i = '0;
      @(negedge clk);
      chk("resp_valid", {63'd0, dmi_resp_valid_o}, 64'd1);
      chk("resp_code", {62'd0, dmi_resp_o[1:0]}, 64'd0);
      r0 = dmi_resp_o;
      s_busy = cmd_busy_o;
      s_halt = haltreq_o;
      s_act = dmactive_o;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_stable", {28'd0, dmi_resp_valid_o, dmi_req_ready_o, dmi_resp_o}, {28'd0, 1'b1, 1'b0, r0});
      end
      rd = r0[33:2];
      dmi_resp_ready_i = 1'b1;
      @(posedge clk);
      #1 dmi_resp_ready_i = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_ni = 1'b0;
      dmi_req_valid_i = 1'b0;
      dmi_resp_ready_i = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;
   endtask

   // reference model: register contents plus absolute edge at which a running command finishes
   logic        m_act, m_halt, m_pend;
   logic [2:0]  m_cmderr;
   logic [31:0] m_data [2];
   logic [7:0]  m_type;
   logic [31:0] m_perf;
   int          m_end;

   task automatic m_clear();
      m_act = 0; m_halt = 0; m_pend = 0; m_cmderr = 0; m_type = 0; m_perf = 0; m_end = 0;
      m_data[0] = 0; m_data[1] = 0;
   endtask

   task automatic m_finish_cmd();
      if (m_type != 0) m_cmderr = 3'd2;
      m_pend = 0;
   endtask

   task automatic m_req(input int e, input logic [6:0] a, input logic [1:0] op, input logic [31:0] d, output logic [31:0] exp);
      logic [31:0] v;
      logic busy;
      if (m_pend && m_end < e) m_finish_cmd();
      busy = m_pend;
      v = 0;
      if (a == 7'h04 || a == 7'h05) v = m_data[a[0]];
      else if (a == 7'h10) v = {m_halt, 30'd0, m_act};
      else if (a == 7'h11) v = 32'h82;
      else if (a == 7'h16) v = 32'd2 + (busy ? 32'h1000 : 32'h0) + 32'(m_cmderr) * 256;
`ifdef DMI_REG_SLAVE_PERF_EN
      else if (a == 7'h7F) v = m_perf;
`endif
      exp = (op == RD) ? v : 32'd0;
      m_perf = m_perf + 1;
      if (op == WR) begin
         if (!m_act) begin
            if (a == 7'h10) m_act = d[0];
         end else if (a == 7'h04 || a == 7'h05) begin
            if (!busy) m_data[a[0]] = d;
            else if (m_cmderr == 0) m_cmderr = 3'd1;
         end else if (a == 7'h10) begin
            m_act = d[0];
            m_halt = d[31];
            if (!d[0]) begin
               m_halt = 0; m_pend = 0; m_cmderr = 0; m_data[0] = 0; m_data[1] = 0;
            end
         end else if (a == 7'h16) m_cmderr = m_cmderr & ~d[10:8];
         else if (a == 7'h17 && m_cmderr == 0) begin
            if (busy) m_cmderr = 3'd1;
            else begin
               m_pend = 1;
               m_end = e + CMD_LAT;
               m_type = d[31:24];
            end
         end
      end
      if (m_pend && m_end == e) m_finish_cmd();
   endtask

   typedef struct packed {
      logic [6:0]  a;
      logic [1:0]  op;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [25];

   initial begin
      logic [31:0] rd, exp;
      logic [6:0]  a;
      logic [1:0]  op;
      logic [31:0] d;
      int b0;
      rst_ni = 1'b0;
      dmi_req_i = '0;
      dmi_req_valid_i = 1'b0;
      dmi_resp_ready_i = 1'b0;
      tbl[0]  = '{7'h11, RD,  32'h0,        32'h82};
      tbl[1]  = '{7'h10, RD,  32'h0,        32'h0};
      tbl[2]  = '{7'h16, RD,  32'h0,        32'h2};
      tbl[3]  = '{7'h04, WR,  32'hDEADBEEF, 32'h0};
      tbl[4]  = '{7'h04, RD,  32'h0,        32'h0};
      tbl[5]  = '{7'h10, WR,  32'h80000001, 32'h0};
      tbl[6]  = '{7'h10, RD,  32'h0,        32'h1};
      tbl[7]  = '{7'h04, WR,  32'hDEADBEEF, 32'h0};
      tbl[8]  = '{7'h04, RD,  32'h0,        32'hDEADBEEF};
      tbl[9]  = '{7'h05, WR,  32'h12345678, 32'h0};
      tbl[10] = '{7'h05, RD,  32'h0,        32'h12345678};
      tbl[11] = '{7'h06, RD,  32'h0,        32'h0};
      tbl[12] = '{7'h10, WR,  32'h80000001, 32'h0};
      tbl[13] = '{7'h10, RD,  32'h0,        32'h80000001};
      tbl[14] = '{7'h04, NOP, 32'h0,        32'h0};
      tbl[15] = '{7'h04, 2'd3, 32'h0,       32'h0};
      tbl[16] = '{7'h04, RD,  32'h0,        32'hDEADBEEF};
      tbl[17] = '{7'h17, RD,  32'h0,        32'h0};
      tbl[18] = '{7'h11, WR,  32'hFFFFFFFF, 32'h0};
      tbl[19] = '{7'h11, RD,  32'h0,        32'h82};
      tbl[20] = '{7'h10, WR,  32'h0,        32'h0};
      tbl[21] = '{7'h04, RD,  32'h0,        32'h0};
      tbl[22] = '{7'h10, RD,  32'h0,        32'h0};
      tbl[23] = '{7'h10, WR,  32'h1,        32'h0};
      tbl[24] = '{7'h05, RD,  32'h0,        32'h0};
      repeat (2) @(negedge clk);
      chk("reset_outputs", {58'd0, dmi_req_ready_o, dmi_resp_valid_o, dmactive_o, haltreq_o, cmd_busy_o, |dmi_resp_o}, {58'd0, 6'b100000});
      rst_ni = 1'b1;

      foreach (tbl[i]) begin
         xact(tbl[i].a, tbl[i].op, tbl[i].d, 0, rd);
         chk($sformatf("vec%0d", i), {32'd0, rd}, {32'd0, tbl[i].exp});
      end

      b0 = busy_tot;
      xact(7'h17, WR, 32'h0, 0, rd);
      xact(7'h17, WR, 32'h0, 0, rd);
      xact(7'h16, RD, 32'h0, 0, rd);
      chk("cmd_collision_cs", {32'd0, rd}, 64'h1102);
      repeat (6) @(negedge clk);
      chk("busy_cycles", 64'(busy_tot - b0), 64'd4);
      xact(7'h16, WR, 32'h100, 0, rd);
      xact(7'h16, RD, 32'h0, 0, rd);
      chk("cmderr_w1c", {32'd0, rd}, 64'h2);

      xact(7'h17, WR, 32'h01000000, 0, rd);
      repeat (8) @(negedge clk);
      xact(7'h16, RD, 32'h0, 0, rd);
      chk("cmdtype_err", {32'd0, rd}, 64'h202);
      b0 = busy_tot;
      xact(7'h17, WR, 32'h0, 0, rd);
      repeat (6) @(negedge clk);
      chk("cmd_ignored_busy", 64'(busy_tot - b0), 64'd0);
      xact(7'h16, RD, 32'h0, 0, rd);
      chk("cmderr_kept", {32'd0, rd}, 64'h202);
      xact(7'h16, WR, 32'h700, 0, rd);

      xact(7'h17, WR, 32'h01000000, 0, rd);
      xact(7'h04, NOP, 32'h0, 0, rd);
      xact(7'h16, WR, 32'h700, 0, rd);
      xact(7'h16, RD, 32'h0, 0, rd);
      chk("w1c_vs_completion", {32'd0, rd}, 64'h202);
      xact(7'h16, WR, 32'h200, 0, rd);

      b0 = busy_tot;
      xact(7'h17, WR, 32'h0, 0, rd);
      xact(7'h04, NOP, 32'h0, 0, rd);
      xact(7'h17, WR, 32'h0, 0, rd);
      xact(7'h16, RD, 32'h0, 0, rd);
      chk("cmd_at_clear_edge", {32'd0, rd}, 64'h102);
      repeat (6) @(negedge clk);
      chk("busy_cycles_edge", 64'(busy_tot - b0), 64'd4);
      xact(7'h16, WR, 32'h100, 0, rd);

      xact(7'h17, WR, 32'h0, 0, rd);
      xact(7'h04, WR, 32'h11111111, 0, rd);
      repeat (6) @(negedge clk);
      xact(7'h04, RD, 32'h0, 0, rd);
      chk("data_wr_busy", {32'd0, rd}, 64'h0);
      xact(7'h16, RD, 32'h0, 0, rd);
      chk("data_wr_busy_err", {32'd0, rd}, 64'h102);
      xact(7'h16, WR, 32'h100, 0, rd);

      xact(7'h04, WR, 32'hA5A55A5A, 0, rd);
      xact(7'h04, RD, 32'h0, 10, rd);
      chk("held_read", {32'd0, rd}, {32'd0, 32'hA5A55A5A});

      xact(7'h17, WR, 32'h0, 0, rd);
      @(negedge clk);
      dmi_req_i = {7'h11, RD, 32'h0};
      dmi_req_valid_i = 1'b1;
      @(posedge clk);
      #1 dmi_req_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_abort", {61'd0, dmi_resp_valid_o, dmi_req_ready_o, cmd_busy_o}, {61'd0, 3'b101});
      #2 rst_ni = 1'b0;
      #1 chk("reset_abort", {26'd0, dmi_resp_valid_o, dmi_req_ready_o, cmd_busy_o, dmactive_o, dmi_resp_o}, {26'd0, 4'b0100, 34'd0});
      @(negedge clk);
      rst_ni = 1'b1;

      for (int i = 0; i < 5; i++) xact(7'h00, NOP, 32'h0, 0, rd);
      xact(7'h7F, RD, 32'h0, 0, rd);
`ifdef DMI_REG_SLAVE_PERF_EN
      chk("perf_count", {32'd0, rd}, 64'd5);
`else
      chk("perf_absent", {32'd0, rd}, 64'd0);
`endif

      do_reset();
      m_clear();
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            0: a = 7'h04;
            1: a = 7'h05;
            2: a = 7'h06;
            3: a = 7'h10;
            4: a = 7'h11;
            5: a = 7'h16;
            6: a = 7'h17;
            7: a = 7'h7F;
            8: a = 7'($urandom_range(0, 127));
            default: a = 7'h17;
         endcase
         op = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : ($urandom_range(0, 1) ? WR : RD);
         d = $urandom;
         if (a == 7'h10) d[0] = ($urandom_range(0, 7) != 0);
         if (a == 7'h17) d[31:24] = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h00;
         repeat ($urandom_range(0, 4)) @(negedge clk);
         xact(a, op, d, $urandom_range(0, 2), rd);
         m_req(e_acc, a, op, d, exp);
         chk($sformatf("rand%0d_a%0h_op%0d", k, a, op), {32'd0, rd}, {32'd0, exp});
         chk("rand_status", {61'd0, s_busy, s_halt, s_act}, {61'd0, m_pend, m_halt, m_act});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dmi_reg_slave.md
Name: dmi_reg_slave

Overview:
- DMI target on the core clock domain, directly downstream of the JTAG DTM clock-domain crossing.
- Consumes dm::dmi_req_t requests and returns exactly one dm::dmi_resp_t per request.
- Implements a reduced debug-module register map: data0..dataN-1, dmcontrol, dmstatus, abstractcs, command.
- Abstract commands execute over a fixed multi-cycle busy window.
- Used as the bring-up DM and as the DTM's system-level bench target.

Parameters:
- NrDataRegs, 2, number of dataN registers; legal range 1..12.
- CmdLatency, 4, cycles abstractcs.busy stays high per accepted command; legal range 1..255.

Ports:
- clk_i  in  1  core/DMI clock
- rst_ni  in  1  reset; asynchronous, active-low
- dmi_req_i  in  41  dm::dmi_req_t {addr[6:0], op[1:0], data[31:0]}
- dmi_req_valid_i  in  1  request valid
- dmi_req_ready_o  out  1  request ready
- dmi_resp_o  out  34  dm::dmi_resp_t {data[31:0], resp[1:0]}
- dmi_resp_valid_o  out  1  response valid
- dmi_resp_ready_i  in  1  response ready
- dmactive_o  out  1  dmcontrol.dmactive
- haltreq_o  out  1  dmcontrol.haltreq
- cmd_busy_o  out  1  abstractcs.busy

Behaviour:
- Reset values:
  - All outputs 0; FSM in Idle; all registers 0.
  - dmi_req_ready_o is 1 in Idle after reset.
- FSM Idle:
  - dmi_req_ready_o=1.
  - Request accepted on valid&ready at edge t, then go to Resp.
  - Writes and register side effects commit at edge t.
- FSM Resp:
  - dmi_req_ready_o=0; dmi_resp_valid_o=1 from cycle t+1.
  - dmi_resp_o held stable until dmi_resp_ready_i, then return to Idle.
  - Next request accepted no earlier than the cycle after the response handshake: one outstanding request max.
- Ops:
  - DTM_NOP: no side effects; response data 0.
  - DTM_READ: response data = register value sampled at edge t, i.e. pre-write state.
  - DTM_WRITE: response data 0. resp always 2'b00.
  - Reserved op 3: treated as NOP.
- Address map:
  - 0x04..0x04+NrDataRegs-1: dataN, R/W.
  - 0x10 dmcontrol: bit0 dmactive, bit31 haltreq; other bits read 0.
  - 0x11 dmstatus: read-only; version[3:0]=2, authenticated bit7=1, rest 0.
  - 0x16 abstractcs:
    - datacount[3:0]=NrDataRegs; progbufsize[28:24]=0; busy bit12.
    - cmderr[10:8] is write-1-to-clear per bit.
  - 0x17 command: write-only; reads 0.
  - Unmapped addresses: reads 0, writes ignored, resp still 0.
- dmactive=0:
  - dataN, haltreq, cmderr, busy and the command counter are held at 0.
  - Only dmactive is writable; a write setting dmactive takes effect for later requests only.
- Command write, processed in this order:
  1. If cmderr!=0, ignore.
  2. Else if busy, set cmderr=1 and ignore.
  3. Else set busy=1 and load counter=CmdLatency.
- Counter behaviour:
  - Decrements each cycle while busy; busy clears in the cycle the counter reaches 0.
  - On completion, cmdtype (bits 31:24)!=0 sets cmderr=2; cmdtype 0 completes with no error.
- dataN write while busy: set cmderr=1 (only if cmderr==0); data unchanged.
- Simultaneous events:
  - cmderr W1C in the same cycle as command completion: the completion error wins.
  - Busy clears in the same cycle a new command arrives: the write still sees busy, so cmderr=1.
- Reset mid-operation: asynchronous reset aborts any busy window or pending response immediately; all outputs go to their reset values.

Optional Feature:
- Macro: DMI_REG_SLAVE_PERF_EN.
- When defined:
  - Adds read-only address 0x7F: 32-bit count of accepted requests, NOPs included.
  - Count increments on each req handshake, wraps 0xFFFFFFFF->0, and resets only on rst_ni (not dmactive).
  - A read returns the count excluding the read itself.
- When undefined: 0x7F behaves as unmapped (reads 0) and no counter flops exist.

Test Plan:
- Reset then read 0x11 -> resp data 0x00000082, resp 0, valid one cycle after accept.
- Write 0x10=0x00000001, write 0x04=0xDEADBEEF, read 0x04 -> 0xDEADBEEF; with dmactive=0 the same write then read -> 0.
- dmactive=1, write 0x17=0x00000000:
  - cmd_busy_o high exactly 4 cycles.
  - A second command write during busy -> 0x16 reads cmderr=1, busy unaffected.
  - Write 0x16 bit8 -> cmderr=0.
- Write 0x17=0x01000000 -> after busy window 0x16 cmderr=2; further command writes ignored, busy stays 0.
- Hold dmi_resp_ready_i=0 for 10 cycles after a read -> response stable, dmi_req_ready_o=0 throughout; assert rst_ni low mid-hold -> valid drops immediately.
- With DMI_REG_SLAVE_PERF_EN: 5 NOP requests, then read 0x7F -> 5; without the macro -> 0.
